mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 21 ++
 rtl/mem_arbiter_if.sv | 44 ++++
 rtl/mem_arbiter_timer.sv | 28 ++
 rtl/mem_arbiter.sv | 105 ++++++++++
 tb/tb_mem_arbiter.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared CPU/memory types for the memory arbiter: word, RAM status and arbiter FSM state.
package cpu_types_pkg;
  localparam int WORD_W  = 32;
  localparam int TIMER_W = 8;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DREQ = 2'b01,
    IREQ = 2'b10,
    ERR  = 2'b11
  } arb_state_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between CPU fetch/data ports, the arbiter and the RAM.
// ARB_PERF_CNT_EN adds the icount/dcount transfer counters to the bundle.
interface mem_arbiter_if;
  import cpu_types_pkg::*;

  logic      iREN;
  word_t     iaddr;
  word_t     iload;
  logic      iwait;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  word_t     dload;
  logic      dwait;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;
  logic      err;
`ifdef ARB_PERF_CNT_EN
  word_t     icount;
  word_t     dcount;
`endif

  // master: the arbiter's view; slave: the CPU/RAM environment's view
  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, err
`ifdef ARB_PERF_CNT_EN
    , output icount, dcount
`endif
  );

  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, err
`ifdef ARB_PERF_CNT_EN
    , input icount, dcount
`endif
  );
endinterface

// File: rtl/mem_arbiter_timer.sv
// Wait-cycle counter for the arbiter: counts enabled cycles, flags the last one before TIMEOUT.
module arb_timer
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [TIMER_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear)       count_d = '0;
    else if (enable) count_d = count_q + 1'b1;
  end

  // Fires during the cycle whose increment would bring the count to TIMEOUT
  assign expired = enable && (count_q == TIMER_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) to single-RAM arbiter, data has priority, with abort on RAM error or timeout.
// ARB_PERF_CNT_EN adds icount/dcount completed-transfer counters.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input logic           CLK,
  input logic           RST,
  mem_arbiter_if.master bus
);
  arb_state_t state_q, state_d;
  logic       err_q;
  logic       d_req, i_req, owner_req, access, ram_err;
  logic       i_done, d_done, tmr_clr, tmr_en, expired;

  always_comb begin
    d_req     = bus.dREN | bus.dWEN;
    i_req     = bus.iREN;
    access    = (bus.ramstate == ACCESS);
    ram_err   = (bus.ramstate == ERROR);
    owner_req = ((state_q == DREQ) && d_req) || ((state_q == IREQ) && i_req);
    d_done    = (state_q == DREQ) && d_req && access;
    i_done    = (state_q == IREQ) && i_req && access;
    tmr_en    = owner_req && !access && !ram_err;

    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (d_req)      state_d = DREQ;
        else if (i_req) state_d = IREQ;
      end
      DREQ, IREQ: begin
        if (!owner_req || access)  state_d = IDLE;
        else if (ram_err || expired) state_d = ERR;
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    tmr_clr = (state_d != state_q);
  end

  arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (CLK),
    .rst     (RST),
    .clear   (tmr_clr),
    .enable  (tmr_en),
    .expired (expired)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= (state_d == ERR);
    end
  end

  // RAM is driven only by the current owner; a dropped request gates the enables itself
  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    case (state_q)
      DREQ: begin
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = bus.dREN & ~bus.dWEN;
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
      end
      IREQ: begin
        bus.ramREN  = bus.iREN;
        bus.ramaddr = bus.iaddr;
      end
      default: ;
    endcase
  end

  assign bus.iwait = ~i_done;
  assign bus.dwait = ~d_done;
  assign bus.iload = i_done ? bus.ramload : '0;
  assign bus.dload = d_done ? bus.ramload : '0;
  assign bus.err   = err_q;

`ifdef ARB_PERF_CNT_EN
  word_t icount_q, dcount_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      icount_q <= '0;
      dcount_q <= '0;
    end else begin
      if (i_done) icount_q <= icount_q + 1'b1;
      if (d_done) dcount_q <= dcount_q + 1'b1;
    end
  end

  assign bus.icount = icount_q;
  assign bus.dcount = dcount_q;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (TIMEOUT=4); inputs change on the falling edge, outputs are sampled 1 time unit later.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic CLK;
  logic RST;
  int   passed;
  int   total;

  mem_arbiter_if bus();

  mem_arbiter #(.TIMEOUT(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic clear_inputs();
    bus.iREN     = 1'b0;
    bus.iaddr    = '0;
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    bus.ramload  = '0;
    bus.ramstate = FREE;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    bus.iREN = 1'b1; bus.dREN = 1'b1; bus.daddr = 32'h100; #1;
    total++; if (bus.ramREN !== 1'b0) $display("FAIL rst_ramREN act=%0h req=0", bus.ramREN); else passed++;
    total++; if (bus.ramWEN !== 1'b0) $display("FAIL rst_ramWEN act=%0h req=0", bus.ramWEN); else passed++;
    total++; if (bus.ramaddr !== 32'h0) $display("FAIL rst_ramaddr act=%0h req=0", bus.ramaddr); else passed++;
    total++; if (bus.err !== 1'b0) $display("FAIL rst_err act=%0h req=0", bus.err); else passed++;
    total++; if (bus.iwait !== 1'b1) $display("FAIL rst_iwait act=%0h req=1", bus.iwait); else passed++;
    total++; if (bus.dwait !== 1'b1) $display("FAIL rst_dwait act=%0h req=1", bus.dwait); else passed++;
    total++; if (bus.iload !== 32'h0) $display("FAIL rst_iload act=%0h req=0", bus.iload); else passed++;
    total++; if (bus.dload !== 32'h0) $display("FAIL rst_dload act=%0h req=0", bus.dload); else passed++;
    @(negedge CLK); #1;
    total++; if (dut.state_q !== IDLE) $display("FAIL rst_state act=%0d req=%0d", dut.state_q, IDLE); else passed++;
    total++; if (bus.ramREN !== 1'b0) $display("FAIL rst_hold_ramREN act=%0h req=0", bus.ramREN); else passed++;
    clear_inputs();
    RST = 1'b0;
    @(negedge CLK); #1;
    total++; if (bus.ramREN !== 1'b0) $display("FAIL rst_release_ramREN act=%0h req=0", bus.ramREN); else passed++;
  endtask

  task automatic test_fetch();
    @(negedge CLK);
    bus.iREN = 1'b1; bus.iaddr = 32'h40; bus.ramstate = BUSY; #1;
    total++; if (bus.iwait !== 1'b1) $display("FAIL fetch_c1_iwait act=%0h req=1", bus.iwait); else passed++;
    total++; if (bus.ramREN !== 1'b0) $display("FAIL fetch_c1_ramREN act=%0h req=0", bus.ramREN); else passed++;
    @(negedge CLK); #1;
    total++; if (bus.ramREN !== 1'b1) $display("FAIL fetch_c2_ramREN act=%0h req=1", bus.ramREN); else passed++;
    total++; if (bus.ramaddr !== 32'h40) $display("FAIL fetch_c2_ramaddr act=%0h req=40", bus.ramaddr); else passed++;
    total++; if (bus.iload !== 32'h0) $display("FAIL fetch_c2_iload act=%0h req=0", bus.iload); else passed++;
    @(negedge CLK);
    bus.ramstate = ACCESS; bus.ramload = 32'hDEADBEEF; #1;
    total++; if (bus.iwait !== 1'b0) $display("FAIL fetch_c3_iwait act=%0h req=0", bus.iwait); else passed++;
    total++; if (bus.iload !== 32'hDEADBEEF) $display("FAIL fetch_c3_iload act=%0h req=deadbeef", bus.iload); else passed++;
    @(negedge CLK);
    bus.iREN = 1'b0; bus.ramstate = FREE; bus.ramload = '0; #1;
    total++; if (dut.state_q !== IDLE) $display("FAIL fetch_idle_state act=%0d req=%0d", dut.state_q, IDLE); else passed++;
    total++; if (bus.iload !== 32'h0) $display("FAIL fetch_idle_iload act=%0h req=0", bus.iload); else passed++;
  endtask

  task automatic test_priority();
    @(negedge CLK);
    bus.iREN = 1'b1; bus.iaddr = 32'h40; bus.dREN = 1'b1; bus.daddr = 32'h100; bus.ramstate = BUSY; #1;
    total++; if (bus.dwait !== 1'b1) $display("FAIL prio_idle_dwait act=%0h req=1", bus.dwait); else passed++;
    @(negedge CLK); #1;
    total++; if (bus.ramaddr !== 32'h100) $display("FAIL prio_data_addr act=%0h req=100", bus.ramaddr); else passed++;
    total++; if (bus.ramREN !== 1'b1) $display("FAIL prio_data_ramREN act=%0h req=1", bus.ramREN); else passed++;
    bus.ramstate = ACCESS; bus.ramload = 32'hCAFEF00D; #1;
    total++; if (bus.dwait !== 1'b0) $display("FAIL prio_data_dwait act=%0h req=0", bus.dwait); else passed++;
    total++; if (bus.dload !== 32'hCAFEF00D) $display("FAIL prio_data_dload act=%0h req=cafef00d", bus.dload); else passed++;
    total++; if (bus.iwait !== 1'b1) $display("FAIL prio_data_iwait act=%0h req=1", bus.iwait); else passed++;
    @(negedge CLK);
    bus.dREN = 1'b0; bus.ramstate = BUSY; bus.ramload = '0; #1;
    total++; if (dut.state_q !== IDLE) $display("FAIL prio_bubble_state act=%0d req=%0d", dut.state_q, IDLE); else passed++;
    total++; if (bus.ramREN !== 1'b0) $display("FAIL prio_bubble_ramREN act=%0h req=0", bus.ramREN); else passed++;
    total++; if (bus.iwait !== 1'b1) $display("FAIL prio_bubble_iwait act=%0h req=1", bus.iwait); else passed++;
    @(negedge CLK); #1;
    total++; if (bus.ramaddr !== 32'h40) $display("FAIL prio_fetch_addr act=%0h req=40", bus.ramaddr); else passed++;
    total++; if (bus.ramREN !== 1'b1) $display("FAIL prio_fetch_ramREN act=%0h req=1", bus.ramREN); else passed++;
    bus.ramstate = ACCESS; bus.ramload = 32'h11111111; #1;
    total++; if (bus.iwait !== 1'b0) $display("FAIL prio_fetch_iwait act=%0h req=0", bus.iwait); else passed++;
    total++; if (bus.iload !== 32'h11111111) $display("FAIL prio_fetch_iload act=%0h req=11111111", bus.iload); else passed++;
    @(negedge CLK);
    clear_inputs(); #1;
    total++; if (dut.state_q !== IDLE) $display("FAIL prio_end_state act=%0d req=%0d", dut.state_q, IDLE); else passed++;
  endtask

  task automatic test_write();
    @(negedge CLK);
    bus.dWEN = 1'b1; bus.dREN = 1'b1; bus.daddr = 32'h200; bus.dstore = 32'h12345678; bus.ramstate = BUSY; #1;
    total++; if (bus.ramstore !== 32'h0) $display("FAIL wr_idle_ramstore act=%0h req=0", bus.ramstore); else passed++;
    @(negedge CLK); #1;
    total++; if (bus.ramWEN !== 1'b1) $display("FAIL wr_ramWEN act=%0h req=1", bus.ramWEN); else passed++;
    total++; if (bus.ramREN !== 1'b0) $display("FAIL wr_ramREN act=%0h req=0", bus.ramREN); else passed++;
    total++; if (bus.ramstore !== 32'h12345678) $display("FAIL wr_ramstore act=%0h req=12345678", bus.ramstore); else passed++;
    total++; if (bus.ramaddr !== 32'h200) $display("FAIL wr_ramaddr act=%0h req=200", bus.ramaddr); else passed++;
    bus.ramstate = ACCESS; #1;
    total++; if (bus.dwait !== 1'b0) $display("FAIL wr_dwait act=%0h req=0", bus.dwait); else passed++;
    @(negedge CLK);
    clear_inputs(); #1;
    total++; if (bus.ramWEN !== 1'b0) $display("FAIL wr_end_ramWEN act=%0h req=0", bus.ramWEN); else passed++;
  endtask

  task automatic test_timeout();
    @(negedge CLK);
    bus.dREN = 1'b1; bus.daddr = 32'h300; bus.ramstate = BUSY;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK); #1;
      total++; if (bus.err !== 1'b0) $display("FAIL to_wait%0d_err act=%0h req=0", c, bus.err); else passed++;
      total++; if (bus.dwait !== 1'b1) $display("FAIL to_wait%0d_dwait act=%0h req=1", c, bus.dwait); else passed++;
      total++; if (bus.ramREN !== 1'b1) $display("FAIL to_wait%0d_ramREN act=%0h req=1", c, bus.ramREN); else passed++;
    end
    @(negedge CLK); #1;
    total++; if (bus.err !== 1'b1) $display("FAIL to_err_pulse act=%0h req=1", bus.err); else passed++;
    total++; if (bus.dwait !== 1'b1) $display("FAIL to_err_dwait act=%0h req=1", bus.dwait); else passed++;
    total++; if (bus.ramREN !== 1'b0) $display("FAIL to_err_ramREN act=%0h req=0", bus.ramREN); else passed++;
    @(negedge CLK); #1;
    total++; if (bus.err !== 1'b0) $display("FAIL to_idle_err act=%0h req=0", bus.err); else passed++;
    total++; if (dut.state_q !== IDLE) $display("FAIL to_idle_state act=%0d req=%0d", dut.state_q, IDLE); else passed++;
    total++; if (bus.dwait !== 1'b1) $display("FAIL to_idle_dwait act=%0h req=1", bus.dwait); else passed++;
    @(negedge CLK); #1;
    total++; if (bus.ramREN !== 1'b1) $display("FAIL to_retry_ramREN act=%0h req=1", bus.ramREN); else passed++;
    total++; if (bus.err !== 1'b0) $display("FAIL to_retry_err act=%0h req=0", bus.err); else passed++;
    bus.ramstate = ACCESS; bus.ramload = 32'h0BADF00D; #1;
    total++; if (bus.dload !== 32'h0BADF00D) $display("FAIL to_retry_dload act=%0h req=badf00d", bus.dload); else passed++;
    @(negedge CLK);
    clear_inputs(); #1;
    total++; if (dut.state_q !== IDLE) $display("FAIL to_end_state act=%0d req=%0d", dut.state_q, IDLE); else passed++;
  endtask

  task automatic test_ram_error();
    @(negedge CLK);
    bus.iREN = 1'b1; bus.iaddr = 32'h80; bus.ramstate = BUSY;
    @(negedge CLK);
    bus.ramstate = ERROR; #1;
    total++; if (bus.iwait !== 1'b1) $display("FAIL rerr_iwait act=%0h req=1", bus.iwait); else passed++;
    total++; if (bus.err !== 1'b0) $display("FAIL rerr_pre_err act=%0h req=0", bus.err); else passed++;
    @(negedge CLK);
    clear_inputs(); #1;
    total++; if (bus.err !== 1'b1) $display("FAIL rerr_pulse act=%0h req=1", bus.err); else passed++;
    total++; if (bus.ramREN !== 1'b0) $display("FAIL rerr_ramREN act=%0h req=0", bus.ramREN); else passed++;
    @(negedge CLK); #1;
    total++; if (bus.err !== 1'b0) $display("FAIL rerr_post_err act=%0h req=0", bus.err); else passed++;
  endtask

  task automatic test_drop();
    @(negedge CLK);
    bus.iREN = 1'b1; bus.iaddr = 32'h44; bus.ramstate = BUSY;
    @(negedge CLK); #1;
    total++; if (bus.ramREN !== 1'b1) $display("FAIL drop_pre_ramREN act=%0h req=1", bus.ramREN); else passed++;
    bus.iREN = 1'b0; #1;
    total++; if (bus.ramREN !== 1'b0) $display("FAIL drop_gate_ramREN act=%0h req=0", bus.ramREN); else passed++;
    @(negedge CLK);
    clear_inputs(); #1;
    total++; if (dut.state_q !== IDLE) $display("FAIL drop_state act=%0d req=%0d", dut.state_q, IDLE); else passed++;
  endtask

`ifdef ARB_PERF_CNT_EN
  task automatic test_perf();
    #1;
    total++; if (bus.icount !== 32'd2) $display("FAIL perf_icount act=%0d req=2", bus.icount); else passed++;
    total++; if (bus.dcount !== 32'd3) $display("FAIL perf_dcount act=%0d req=3", bus.dcount); else passed++;
  endtask
`endif

  task automatic test_reset_mid();
    @(negedge CLK);
    bus.dREN = 1'b1; bus.daddr = 32'h500; bus.ramstate = BUSY;
    @(negedge CLK); #1;
    total++; if (bus.ramREN !== 1'b1) $display("FAIL rmid_pre_ramREN act=%0h req=1", bus.ramREN); else passed++;
    RST = 1'b1; #1;
    total++; if (bus.ramREN !== 1'b0) $display("FAIL rmid_ramREN act=%0h req=0", bus.ramREN); else passed++;
    total++; if (dut.state_q !== IDLE) $display("FAIL rmid_state act=%0d req=%0d", dut.state_q, IDLE); else passed++;
    total++; if (bus.dwait !== 1'b1) $display("FAIL rmid_dwait act=%0h req=1", bus.dwait); else passed++;
`ifdef ARB_PERF_CNT_EN
    total++; if (bus.dcount !== 32'd0) $display("FAIL rmid_dcount act=%0d req=0", bus.dcount); else passed++;
    total++; if (bus.icount !== 32'd0) $display("FAIL rmid_icount act=%0d req=0", bus.icount); else passed++;
`endif
    @(negedge CLK); #1;
    total++; if (bus.ramREN !== 1'b0) $display("FAIL rmid_hold_ramREN act=%0h req=0", bus.ramREN); else passed++;
    clear_inputs();
    RST = 1'b0;
    @(negedge CLK); #1;
    total++; if (bus.ramREN !== 1'b0) $display("FAIL rmid_end_ramREN act=%0h req=0", bus.ramREN); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    RST    = 1'b1;
    clear_inputs();
    test_reset();
    test_fetch();
    test_priority();
    test_write();
    test_timeout();
    test_ram_error();
    test_drop();
`ifdef ARB_PERF_CNT_EN
    test_perf();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
